// File: rtl/console_rx.sv
// rtl/console_rx.sv - Wishbone B4 slave 8N1 UART receiver with receive FIFO
// Byte-level receive FSM feeding a small FIFO, exposed via RXDATA/STATUS registers.
module console_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack,
  input  logic        rx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          rx_m, rx_s;
  logic          push, ferr_set;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow, frame_err;
  logic          empty, full;
  logic          req, pop, push_ok, ovf_set, clr_ovf, clr_ferr;
  logic [31:0]   rd_mux;
  logic          unused_bits;

  // Two-flop synchroniser; idle-high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shift <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    shift_nxt = shift;
    push      = 1'b0;
    ferr_set  = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = S_START;
      end
      S_START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt        = '0;
          shift_nxt[idx] = rx_s;
          idx_nxt        = idx + 3'd1;
          if (idx == 3'd7) state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          push      = rx_s;
          ferr_set  = !rx_s;
          state_nxt = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        // A held-low break line yields a single frame error, not a stream of them.
        cnt_nxt = '0;
        if (rx_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign empty    = (count == '0);
  assign full     = (count == DEPTH);
  assign req      = wb_cyc & wb_stb & ~wb_ack;
  assign pop      = req & ~wb_we & (wb_adr[3:2] == 2'd0) & ~empty;
  assign clr_ovf  = req & wb_we & (wb_adr[3:2] == 2'd1) & wb_dat_i[1];
  assign clr_ferr = req & wb_we & (wb_adr[3:2] == 2'd1) & wb_dat_i[2];
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok  = push & (~full | pop);
  assign ovf_set  = push & full & ~pop;

  assign unused_bits = ^{wb_adr[31:4], wb_adr[1:0], wb_dat_i[31:3], wb_dat_i[0]};

  always_comb begin
    rd_mux = '0;
    case (wb_adr[3:2])
      2'd0:    if (!empty) rd_mux = {24'b0, mem[rd_ptr]};
      2'd1:    rd_mux = {19'b0, 9'(count), 1'b0, frame_err, overflow, ~empty};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_ack   <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack   <= req;
      wb_dat_o <= (req && !wb_we) ? rd_mux : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count     <= count + CW'(push_ok) - CW'(pop);
      // Receiver set takes priority over a software clear in the same cycle.
      overflow  <= (overflow & ~clr_ovf) | ovf_set;
      frame_err <= (frame_err & ~clr_ferr) | ferr_set;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shift;
  end

endmodule

// File: tb/tb_console_rx.sv
// tb/tb_console_rx.sv - self-checking bench for console_rx against a byte-level queue model
module tb_console_rx;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        ack;
  logic        rx = 1'b1;

  always #5 clk = ~clk;

  console_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we),
    .wb_adr(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_ack(ack), .rx(rx)
  );

  int n_checks = 0;
  int n_fail   = 0;
  byte unsigned mq[$];
  bit m_ovf  = 1'b0;
  bit m_ferr = 1'b0;
  bit prev_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s    = 32'(mq.size()) << 4;
    s[0] = (mq.size() != 0);
    s[1] = m_ovf;
    s[2] = m_ferr;
    return s;
  endfunction

  // Every acked cycle: compare read data with the model and apply the access's side effects.
  always @(posedge clk) begin
    logic [31:0] exp;
    #1;
    if (rst) begin
      if (ack) begin
        check("ack_back_to_back", 32'(prev_ack), 32'd0);
        if (!we) begin
          case (adr[3:2])
            2'd0: begin
              exp = (mq.size() != 0) ? 32'(mq[0]) : 32'd0;
              if (mq.size() != 0) void'(mq.pop_front());
            end
            2'd1:    exp = m_status();
            default: exp = 32'd0;
          endcase
          check("bus_read", dat_o, exp);
        end else if (adr[3:2] == 2'd1) begin
          if (dat_i[1]) m_ovf = 1'b0;
          if (dat_i[2]) m_ferr = 1'b0;
        end
      end
      prev_ack = ack;
    end else begin
      prev_ack = 1'b0;
    end
  end

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] q);
    bit got;
    got = 1'b0;
    q   = 'x;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        got = 1'b1;
        q   = dat_o;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL wb_timeout: got no ack, expected ack within 8 cycles");
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] q);
    wb_xfer(1'b0, a, 32'd0, q);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(1'b1, a, d, q);
  endtask

  task automatic hold_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good);
    @(negedge clk);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(good);
    rx = 1'b1;
    if (good) begin
      if (mq.size() < DEPTH) mq.push_back(b);
      else m_ovf = 1'b1;
    end else begin
      m_ferr = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; rx = 1'b1;
    mq.delete();
    m_ovf = 1'b0; m_ferr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q;
    logic [5:0]  pat;
    bit          polled;

    #12;
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_dat_o", dat_o, 32'd0);
    do_reset();

    // Single byte
    send_frame(8'h55, 1'b1);
    polled = 1'b0;
    for (int i = 0; i < 20 && !polled; i++) begin
      rd(32'h4, q);
      polled = q[0];
    end
    check("poll_not_empty", 32'(polled), 32'd1);
    rd(32'h0, q); check("single_byte", q, 32'h55);
    rd(32'h4, q); check("single_status_after", q, 32'h0);

    // Back-to-back bytes
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    send_frame(8'hFF, 1'b1);
    rd(32'h4, q); check("b2b_status", q, 32'h31);
    rd(32'h0, q); check("b2b_0", q, 32'hA5);
    rd(32'h0, q); check("b2b_1", q, 32'h3C);
    rd(32'h0, q); check("b2b_2", q, 32'hFF);
    rd(32'h0, q); check("b2b_empty_read", q, 32'h0);

    // Overflow
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    rd(32'h4, q); check("ovf_status", q, 32'h43);
    for (int i = 1; i <= 4; i++) begin
      rd(32'h0, q); check("ovf_read", q, 32'(i));
    end
    wr(32'h4, 32'h2);
    rd(32'h4, q); check("ovf_w1c", q, 32'h0);

    // Framing error
    send_frame(8'h77, 1'b0);
    rd(32'h4, q); check("ferr_status", q, 32'h4);
    send_frame(8'h12, 1'b1);
    rd(32'h0, q); check("ferr_next_byte", q, 32'h12);
    wr(32'h4, 32'h4);
    rd(32'h4, q); check("ferr_w1c", q, 32'h0);

    // Glitch shorter than half a bit
    @(negedge clk); rx = 1'b0;
    repeat (4) @(negedge clk); rx = 1'b1;
    repeat (40) @(negedge clk);
    rd(32'h4, q); check("glitch_status", q, 32'h0);

    // Held strobe on RXDATA: ack every other cycle, one pop per ack
    send_frame(8'h9A, 1'b1);
    send_frame(8'hBC, 1'b1);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0;
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      pat = {pat[4:0], ack};
    end
    @(negedge clk); cyc = 1'b0; stb = 1'b0;
    check("held_stb_ack_pattern", 32'(pat), 32'b101010);
    rd(32'h4, q); check("held_stb_drained", q, 32'h0);

    // Reset mid-frame while a read is being acked
    send_frame(8'h21, 1'b1);
    @(negedge clk);
    rx = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h4;
    repeat (40) @(negedge clk);
    polled = 1'b0;
    for (int i = 0; i < 4 && !polled; i++) begin
      @(posedge clk); #1;
      polled = ack;
    end
    check("midframe_ack_seen", 32'(polled), 32'd1);
    #1;
    rst = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_ferr = 1'b0;
    #1;
    check("async_reset_ack", 32'(ack), 32'd0);
    check("async_reset_dat_o", dat_o, 32'd0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rd(32'h4, q); check("after_reset_status", q, 32'h0);

    // Randomized traffic checked by the compare process against the model
    for (int it = 0; it < 30; it++) begin
      int nf, nr;
      nf = $urandom_range(1, 5);
      for (int f = 0; f < nf; f++)
        send_frame(8'($urandom), ($urandom_range(0, 7) != 0));
      repeat ($urandom_range(0, 20)) @(negedge clk);
      nr = $urandom_range(0, 6);
      for (int r = 0; r < nr; r++) begin
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 6)       rd(32'h0, q);
        else if (sel == 6) rd(32'h4, q);
        else if (sel == 7) rd(32'(4 * $urandom_range(2, 3)), q);
        else if (sel == 8) wr(32'h4, $urandom);
        else               wr(32'(4 * $urandom_range(0, 3)) & 32'hB, $urandom);
      end
    end
    for (int r = 0; r < 6; r++) rd(32'h0, q);
    rd(32'h4, q);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/console_rx.md
Name: console_rx

Overview:
- Wishbone B4 slave UART receiver; the receive-side counterpart of the console transmitter.
- Samples a serial 8N1 line and buffers received bytes in a small FIFO.
- Exposes data and status registers to the core over the shared WB4 bus so software can read console input.
- Sits on the same bus segment as the console transmitter, at its own address window.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200); minimum 4.
- FIFO_DEPTH, 16, receive FIFO entries; power of two, 2..256.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset), synchronous deassert in the parent.
- wb  WB4 slave modport  -  bus port: cyc, stb, we, adr[31:0], dat_i[31:0], dat_o[31:0], ack.
- rx  input  1  serial line, idle high; asynchronous to clk.

Behaviour:
- Reset (rst=0):
  - ack=0, dat_o=0.
  - FIFO empty; overflow=0, frame_err=0.
  - Receive FSM in IDLE; rx synchroniser flops set to 1.
- Synchroniser: rx passes through 2 flops (rx_s) before any use.
- Receive FSM, with bit counter cnt and bit index idx:
  - IDLE: on rx_s=0, go START, cnt=0.
  - START: wait CLKS_PER_BIT/2 cycles (integer division).
    - If rx_s=1 at that sample, treat as glitch: back to IDLE, nothing stored.
    - Otherwise go DATA, cnt=0, idx=0.
  - DATA: sample rx_s every CLKS_PER_BIT cycles; LSB first into shift[idx]. After idx=7 sampled, go STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rx_s=1: push byte to FIFO.
    - rx_s=0: discard byte, set frame_err sticky.
    - In both cases go WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then IDLE. This covers a break condition: one frame_err only, no repeated triggering.
- FIFO push when full: byte dropped, overflow sticky set, FIFO contents unchanged.
- Register map, decoded on adr[3:2]; adr[31:4] ignored (parent decodes):
  - 0x0 RXDATA (read):
    - dat_o = {24'b0, head byte}.
    - If FIFO not empty, pop in the ack cycle.
    - If empty, return 0 and no pop.
  - 0x0 write: ignored, acked.
  - 0x4 STATUS (read): bit0 = not_empty, bit1 = overflow, bit2 = frame_err, bits[12:4] = fill count, others 0.
  - 0x4 STATUS (write): write-1-to-clear on bits 1 and 2 (dat_i[1], dat_i[2]); other bits ignored.
  - 0x8, 0xC: read 0, writes ignored, acked.
- Handshake:
  - When cyc&stb&!ack, assert ack for exactly one cycle on the next edge, with dat_o registered in that same edge.
  - ack is never asserted two consecutive cycles.
  - A held stb gets ack every second cycle.
  - Read side effects (pop) occur once per ack.
  - Abort (cyc drops before ack): no side effect, since state changes only at the ack edge.
- Simultaneous push and pop in the same cycle:
  - Both take effect; count unchanged.
  - If full at that moment, push succeeds because pop frees a slot; no overflow.
- Simultaneous sticky set by receiver and W1C clear in the same cycle: set wins.
- Count width is clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-frame: FSM aborts to IDLE, partial byte lost. After release, a line still low is treated as a new start edge; this is acceptable, and the resulting frame_err is allowed.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4):
- Single byte:
  - Stimulus: reset pulse; drive frame 0x55 on rx; poll STATUS until bit0=1; read RXDATA.
  - Required response: 0x00000055; then STATUS = 0x0 (empty, count 0).
- Back-to-back bytes:
  - Stimulus: frames 0xA5, 0x3C, 0xFF with no idle gap; read RXDATA three times.
  - Required response: STATUS count=3 before reading; reads return 0xA5, 0x3C, 0xFF in order; fourth read returns 0.
- Overflow:
  - Stimulus: send 5 bytes 0x01..0x05 without reading.
  - Required response: STATUS = count 4, overflow=1 (0x43); reads return 0x01..0x04.
  - Then write 0x2 to STATUS; required response: bit1 cleared.
- Framing error:
  - Stimulus: send 0x77 with stop bit 0, then line high.
  - Required response: no push; STATUS bit2=1, count 0. Following valid 0x12 is received correctly.
- Glitch:
  - Stimulus: rx low for 4 cycles, then high.
  - Required response: no push, no error flags.
- Bus protocol:
  - Stimulus: hold stb=1 on RXDATA with 2 bytes queued.
  - Required response: ack pulses one cycle on, one cycle off; exactly one pop per ack.
  - Stimulus: assert rst=0 mid-frame.
  - Required response: ack=0 and FIFO empty immediately, without a clock edge.
